// File: rtl/donut_pkg.sv
// Shared constants and types for the VGA donut pixel pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package donut_pkg;

    // VGA beam timing, shared with the top level
    localparam logic [10:0] H_DISPLAY = 11'd1220;
    localparam logic [10:0] H_TOTAL   = 11'd1525;
    localparam logic [9:0]  V_DISPLAY = 10'd480;
    localparam logic [9:0]  V_TOTAL   = 10'd525;

    localparam int LUMA_W  = 6;
    localparam int LIGHT_W = 8;

    // Light direction after reset: pointing along +x
    localparam logic signed [LIGHT_W-1:0] LX_RST = 8'sd112;
    localparam logic signed [LIGHT_W-1:0] LY_RST = 8'sd0;

    typedef enum logic [1:0] {IDLE, ROTATE, MUL_X, MUL_Y} state_t;

    // Clamp a rotated light component to the symmetric range +/-127
    function automatic logic signed [LIGHT_W-1:0] sat_light(input logic signed [LIGHT_W:0] v);
        if (v > 9'sd127)
            return 8'sd127;
        else if (v < -9'sd127)
            return -8'sd127;
        else
            return v[LIGHT_W-1:0];
    endfunction

endpackage

// File: rtl/torus_shader_seq_mul.sv
// Sequential signed 8x10 shift-add multiplier, one multiplier bit per cycle.
// Latency: done pulses 10 cycles after start; product holds until the next start.
// Backpressure: none; start must only be raised while the unit is idle.
module seq_mul_s8 (
    input  logic               clk48,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [7:0]  a,
    input  logic signed [9:0]  b,
    output logic               done,
    output logic signed [17:0] product
);

    logic [17:0] acc;
    logic [17:0] a_sh;
    logic [9:0]  b_sh;
    logic [3:0]  cnt;
    logic        busy;
    logic [17:0] a_ext;
    logic [17:0] term;

    assign a_ext   = {{10{a[7]}}, a};
    assign term    = b_sh[0] ? a_sh : 18'd0;
    assign product = acc;

    // Bit 0 is folded into the start cycle; bit 9 carries negative weight
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            acc  <= b[0] ? a_ext : 18'd0;
            a_sh <= a_ext << 1;
            b_sh <= {1'b0, b[9:1]};
            cnt  <= 4'd1;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            acc  <= (cnt == 4'd9) ? acc - term : acc + term;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + 4'd1;
            if (cnt == 4'd9) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/torus_shader.sv
// Annulus shader with rotating directional light; optional rim falloff under TORUS_RIM_EN.
// Latency: 1 cycle from h_count/v_count to donut_luma/donut_visible.
// Backpressure: none; follows the free-running beam, per-frame light update runs in vblank.
module torus_shader
    import donut_pkg::*;
#(
    parameter int CX         = 305,
    parameter int CY         = 240,
    parameter int R_IN       = 90,
    parameter int R_OUT      = 200,
    parameter int AMBIENT    = 24,
    parameter int LUMA_SHIFT = 10,
    parameter int ROT_SHIFT  = 5
) (
    input  logic              clk48,
    input  logic              rst_n,
    input  logic [10:0]       h_count,
    input  logic [9:0]        v_count,
    output logic [LUMA_W-1:0] donut_luma,
    output logic              donut_visible
);

    localparam logic [17:0]        R_IN2      = 18'(R_IN * R_IN);
    localparam logic [17:0]        R_OUT2     = 18'(R_OUT * R_OUT);
    localparam logic signed [10:0] DX0        = 11'(-CX);
    localparam logic signed [10:0] DY0        = 11'(-CY);
    localparam logic [17:0]        DX2_0      = 18'(CX * CX);
    localparam logic [17:0]        DY2_0      = 18'(CY * CY);
    localparam logic signed [9:0]  MUL_BX     = 10'(-CX);
    localparam logic signed [9:0]  MUL_BY     = 10'(-CY);
    localparam logic signed [18:0] BASE_X_RST = 19'(int'(LX_RST) * (-CX));
    localparam logic signed [20:0] AMB        = 21'(AMBIENT);

    // Live light / base products used by the beam, and staged copies for the next frame
    logic signed [7:0]  lx, ly, lx_n, ly_n;
    logic signed [18:0] base_x, base_y, bx_n;

    // Incremental geometry for the current beam position
    logic signed [10:0] dx, dy;
    logic [17:0]        dx2, dy2;
    logic signed [18:0] dotx, doty;

    state_t             state_q, state_d;
    logic               mul_start, mul_done;
    logic signed [7:0]  mul_a;
    logic signed [9:0]  mul_b;
    logic signed [17:0] mul_p;

    // Line/column accumulators: step per column pair, rewind at hblank, reload for frame top
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            dx   <= DX0;
            dx2  <= DX2_0;
            dotx <= BASE_X_RST;
            dy   <= DY0;
            dy2  <= DY2_0;
            doty <= '0;
        end else if (h_count == H_DISPLAY) begin
            dx   <= DX0;
            dx2  <= DX2_0;
            dotx <= base_x;
            if (v_count == V_TOTAL - 10'd1) begin
                dy   <= DY0;
                dy2  <= DY2_0;
                doty <= base_y;
            end else begin
                dy   <= dy + 11'sd1;
                dy2  <= dy2 + {{6{dy[10]}}, dy, 1'b1};
                doty <= doty + {{11{ly[7]}}, ly};
            end
        end else if (h_count[0] && (h_count < H_DISPLAY)) begin
            dx   <= dx + 11'sd1;
            dx2  <= dx2 + {{6{dx[10]}}, dx, 1'b1};
            dotx <= dotx + {{11{lx[7]}}, lx};
        end
    end

    // Shading datapath feeding the output register
    logic [17:0]        d2;
    logic signed [18:0] dot, dot_sh;
    logic signed [20:0] luma_raw, luma_adj;
    logic [LUMA_W-1:0]  luma_sat;
    logic               active, on_ring;

    assign d2       = dx2 + dy2;
    assign dot      = dotx + doty;
    assign dot_sh   = dot >>> LUMA_SHIFT;
    assign luma_raw = {{2{dot_sh[18]}}, dot_sh} + AMB;
    assign active   = (h_count < H_DISPLAY) && (v_count < V_DISPLAY);
    assign on_ring  = (d2 >= R_IN2) && (d2 < R_OUT2);

`ifdef TORUS_RIM_EN
    // Darken towards both edges of the tube, proportional to distance from mid-radius
    localparam int          R_MID  = (R_IN + R_OUT) / 2;
    localparam logic [17:0] R_MID2 = 18'(R_MID * R_MID);
    logic signed [18:0] rim_diff;
    logic [18:0]        rim_abs, rim_pen;
    assign rim_diff = $signed({1'b0, d2}) - $signed({1'b0, R_MID2});
    assign rim_abs  = rim_diff[18] ? 19'(-rim_diff) : rim_diff;
    assign rim_pen  = rim_abs >> 9;
    assign luma_adj = luma_raw - $signed({2'b00, rim_pen});
`else
    assign luma_adj = luma_raw;
`endif

    // Clamp shade into 0..63
    always_comb begin
        luma_sat = luma_adj[LUMA_W-1:0];
        if (luma_adj < 21'sd0)
            luma_sat = '0;
        else if (luma_adj > 21'sd63)
            luma_sat = '1;
    end

    // Output register: blank outside the active area or off the ring
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            donut_luma    <= '0;
            donut_visible <= 1'b0;
        end else begin
            donut_visible <= active && on_ring;
            donut_luma    <= (active && on_ring) ? luma_sat : '0;
        end
    end

    // Light rotation by a small angle; ly uses the already-updated lx
    logic signed [7:0] ly_sh, rot_lx, lx_sh, rot_ly;
    assign ly_sh  = ly >>> ROT_SHIFT;
    assign rot_lx = sat_light($signed({lx[7], lx}) - $signed({ly_sh[7], ly_sh}));
    assign lx_sh  = rot_lx >>> ROT_SHIFT;
    assign rot_ly = sat_light($signed({ly[7], ly}) + $signed({lx_sh[7], lx_sh}));

    seq_mul_s8 u_mul (
        .clk48   (clk48),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_p)
    );

    // Vblank FSM state register
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Vblank FSM sequencing: rotate, then base_x product, then base_y product
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        mul_a     = rot_lx;
        mul_b     = MUL_BX;
        case (state_q)
            IDLE: begin
                if ((v_count == V_DISPLAY) && (h_count == 11'd0))
                    state_d = ROTATE;
            end
            ROTATE: begin
                mul_start = 1'b1;
                state_d   = MUL_X;
            end
            MUL_X: begin
                if (mul_done) begin
                    mul_start = 1'b1;
                    mul_a     = ly_n;
                    mul_b     = MUL_BY;
                    state_d   = MUL_Y;
                end
            end
            MUL_Y: begin
                if (mul_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage the new light and products; commit all together at the end of MUL_Y
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            lx     <= LX_RST;
            ly     <= LY_RST;
            lx_n   <= LX_RST;
            ly_n   <= LY_RST;
            base_x <= BASE_X_RST;
            base_y <= '0;
            bx_n   <= BASE_X_RST;
        end else begin
            if (state_q == ROTATE) begin
                lx_n <= rot_lx;
                ly_n <= rot_ly;
            end
            if ((state_q == MUL_X) && mul_done)
                bx_n <= {mul_p[17], mul_p};
            if ((state_q == MUL_Y) && mul_done) begin
                lx     <= lx_n;
                ly     <= ly_n;
                base_x <= bx_n;
                base_y <= {mul_p[17], mul_p};
            end
        end
    end

endmodule

// File: tb/tb_torus_shader.sv
// Directed bench for torus_shader: compressed frame scans with hand-computed shades.
// Latency: checks sample outputs 1 ns after the edge that registered the driven beam position.
// Backpressure: n/a.
module tb_torus_shader;
    import donut_pkg::*;

    logic        clk48 = 1'b0;
    logic        rst_n;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic [5:0]  donut_luma, luma60;
    logic        donut_visible, vis60;

    int checks   = 0;
    int failures = 0;

`ifdef TORUS_RIM_EN
    localparam int RIM = 2;
`else
    localparam int RIM = 0;
`endif

    torus_shader dut (
        .clk48         (clk48),
        .rst_n         (rst_n),
        .h_count       (h_count),
        .v_count       (v_count),
        .donut_luma    (donut_luma),
        .donut_visible (donut_visible)
    );

    torus_shader #(.AMBIENT(60)) dut60 (
        .clk48         (clk48),
        .rst_n         (rst_n),
        .h_count       (h_count),
        .v_count       (v_count),
        .donut_luma    (luma60),
        .donut_visible (vis60)
    );

    always #5 clk48 = ~clk48;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int h, input int v);
        h_count = 11'(h);
        v_count = 10'(v);
        @(posedge clk48);
        #1;
    endtask

    task automatic check_light(input string tag, input int elx, input int ely, input int ebx, input int eby);
        chk({tag, "_lx"}, dut.lx, elx);
        chk({tag, "_ly"}, dut.ly, ely);
        chk({tag, "_base_x"}, dut.base_x, ebx);
        chk({tag, "_base_y"}, dut.base_y, eby);
        chk({tag, "_state"}, dut.state_q, IDLE);
    endtask

    // One frame; only line 240 is scanned in full, other lines just get their hblank
    task automatic run_frame(input bit do_reset);
        for (int v = 0; v < 525; v++) begin
            if (v == 240) begin
                for (int h = 0; h < 1525; h++) begin
                    step(h, v);
                    if (h == 310) begin
                        chk("luma_dxm150", donut_luma, 7 - RIM);
                        chk("vis_dxm150", donut_visible, 1);
                        chk("luma60_dxm150", luma60, 43 - RIM);
                    end
                    if (h == 610) begin
                        chk("luma_centre", donut_luma, 0);
                        chk("vis_centre", donut_visible, 0);
                    end
                    if (h == 910) begin
                        chk("luma_dx150", donut_luma, 40 - RIM);
                        chk("vis_dx150", donut_visible, 1);
                        chk("luma60_sat", luma60, 63);
                        chk("vis60_dx150", vis60, 1);
                        if (do_reset) begin
                            rst_n = 1'b0;
                            #1;
                            chk("rst_async_luma", donut_luma, 0);
                            chk("rst_async_vis", donut_visible, 0);
                            check_light("rst_mid", 112, 0, -34160, 0);
                        end
                    end
                    if (do_reset && h == 915)
                        rst_n = 1'b1;
                    if (h == 1220 || h == 1524) begin
                        chk("luma_hblank", donut_luma, 0);
                        chk("vis_hblank", donut_visible, 0);
                    end
                end
            end else if (v == 480) begin
                step(0, 480);
                chk("fsm_rotate", dut.state_q, ROTATE);
                repeat (20) step(1, 480);
                chk("fsm_mul_y", dut.state_q, MUL_Y);
                step(1, 480);
                chk("fsm_idle", dut.state_q, IDLE);
                chk("vis_vblank", donut_visible, 0);
                chk("luma_vblank", donut_luma, 0);
                step(1220, 480);
            end else begin
                step(0, v);
                step(1220, v);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        h_count = '0;
        v_count = '0;
        repeat (3) @(posedge clk48);
        #1;
        chk("reset_luma", donut_luma, 0);
        chk("reset_vis", donut_visible, 0);
        check_light("reset", 112, 0, -34160, 0);
        rst_n = 1'b1;

        run_frame(1'b0);
        check_light("vblank1", 112, 3, -34160, -720);
        run_frame(1'b0);
        check_light("vblank2", 112, 6, -34160, -1440);
        run_frame(1'b1);
        check_light("vblank3", 112, 3, -34160, -720);
        run_frame(1'b0);

        step(1600, 600);
        chk("oor_luma", donut_luma, 0);
        chk("oor_vis", donut_visible, 0);
        step(1300, 240);
        chk("oor_h_vis", donut_visible, 0);
        step(900, 700);
        chk("oor_v_luma", donut_luma, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
